// File: rtl/axi_lite_regfile_if.sv
// rtl/axi_lite_regfile_if.sv - AXI4-Lite types package and bus interface
// Package types are shared by the regfile and its bus interface.
package axi_lite_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [1:0]  resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
endpackage

interface axi_lite_if;
  import axi_lite_pkg::*;

  addr_t awaddr;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;
  addr_t araddr;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_regfile.sv
// rtl/axi_lite_regfile.sv - AXI4-Lite slave register file with byte strobes
// Define AXI_LITE_REGFILE_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 8,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  axi_lite_if.slave                s_axi,
  output logic [NUM_REGS*32-1:0]   regs_o
);

  localparam int unsigned IDX_W      = $clog2(NUM_REGS);
  localparam addr_t       ADDR_LIMIT = addr_t'(NUM_REGS * 4);

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t   w_state_q;
  r_state_t   r_state_q;

  logic       aw_full_q;
  addr_t      aw_addr_q;
  logic       w_full_q;
  data_t      w_data_q;
  strb_t      w_strb_q;
  resp_t      bresp_q;
  data_t      rdata_q;
  resp_t      rresp_q;
  data_t      regs_q [NUM_REGS];

  logic       awready, wready, arready;
  logic       aw_hs, w_hs, ar_hs, commit;
  addr_t      cm_addr;
  data_t      cm_data;
  strb_t      cm_strb;
  logic       wr_hit, rd_hit;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  data_t      wr_merged_d;
  resp_t      bresp_d;
  data_t      rdata_d;
  resp_t      rresp_d;

  assign awready = !aw_full_q && (w_state_q == W_IDLE);
  assign wready  = !w_full_q  && (w_state_q == W_IDLE);
  assign arready = (r_state_q == R_IDLE);

  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.bvalid  = (w_state_q == W_RESP);
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready;
  assign s_axi.rvalid  = (r_state_q == R_DATA);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  // A channel arriving this edge bypasses its latch so commit can happen at once.
  always_comb begin
    aw_hs   = s_axi.awvalid && awready;
    w_hs    = s_axi.wvalid && wready;
    ar_hs   = s_axi.arvalid && arready;
    commit  = (aw_full_q || aw_hs) && (w_full_q || w_hs);
    cm_addr = aw_full_q ? aw_addr_q : s_axi.awaddr;
    cm_data = w_full_q  ? w_data_q  : s_axi.wdata;
    cm_strb = w_full_q  ? w_strb_q  : s_axi.wstrb;
    wr_hit  = (cm_addr < ADDR_LIMIT);
    wr_idx  = cm_addr[IDX_W+1:2];
    wr_merged_d = regs_q[wr_idx];
    for (int k = 0; k < 4; k++) begin
      if (cm_strb[k]) wr_merged_d[8*k +: 8] = cm_data[8*k +: 8];
    end
    rd_hit  = (s_axi.araddr < ADDR_LIMIT);
    rd_idx  = s_axi.araddr[IDX_W+1:2];
    rdata_d = rd_hit ? regs_q[rd_idx] : '0;
    bresp_d = RESP_OKAY;
    rresp_d = RESP_OKAY;
`ifdef AXI_LITE_REGFILE_SLVERR_EN
    if (!wr_hit) bresp_d = RESP_SLVERR;
    if (!rd_hit) rresp_d = RESP_SLVERR;
`else
    bresp_d = RESP_OKAY;
    rresp_d = RESP_OKAY;
`endif
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (commit) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bresp_q   <= bresp_d;
            if (wr_hit) regs_q[wr_idx] <= wr_merged_d;
            w_state_q <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_full_q <= 1'b1;
              aw_addr_q <= s_axi.awaddr;
            end
            if (w_hs) begin
              w_full_q <= 1'b1;
              w_data_q <= s_axi.wdata;
              w_strb_q <= s_axi.wstrb;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // rdata samples regs_q before any same-edge commit lands, so a colliding read sees the old value.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi.rready) r_state_q <= R_IDLE;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
    assign regs_o[32*gi +: 32] = regs_q[gi];
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb/tb_axi_lite_regfile.sv - randomized self-checking bench for axi_lite_regfile
module tb_axi_lite_regfile;
  import axi_lite_pkg::*;

  localparam int N = 8;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [N*32-1:0] regs_o;
  int              errors = 0;
  int              checks = 0;
  logic [31:0]     model [N];

  axi_lite_if bus();

  axi_lite_regfile #(.NUM_REGS(N), .RESET_VAL(32'h0000_0000)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axi   (bus),
    .regs_o  (regs_o)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    if (a < 32'(N * 4)) return 2'b00;
`ifdef AXI_LITE_REGFILE_SLVERR_EN
    return 2'b10;
`else
    return 2'b00;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a >= 32'(N * 4)) return 32'h0;
    return model[a / 4];
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = 32'h0;
    for (int k = 0; k < 4; k++) if (s[k]) mask = mask | (32'hFF << (8 * k));
    if (a < 32'(N * 4)) model[a / 4] = (model[a / 4] & ~mask) | (d & mask);
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < N; i++) check(tag, regs_o[32*i +: 32], model[i]);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_awready"}, 32'(bus.awready), 32'd1);
    check({tag, "_wready"},  32'(bus.wready),  32'd1);
    check({tag, "_arready"}, 32'(bus.arready), 32'd1);
    check({tag, "_bvalid"},  32'(bus.bvalid),  32'd0);
    check({tag, "_rvalid"},  32'(bus.rvalid),  32'd0);
    check({tag, "_bresp"},   32'(bus.bresp),   32'd0);
    check({tag, "_rresp"},   32'(bus.rresp),   32'd0);
    check({tag, "_rdata"},   bus.rdata,        32'd0);
    for (int i = 0; i < N; i++) check({tag, "_reg"}, regs_o[32*i +: 32], 32'h0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_stall);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    logic [1:0] resp0;
    aw_done = 0; w_done = 0; cyc = 0;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      bus.awvalid = !aw_done && (cyc >= aw_dly);
      bus.wvalid  = !w_done  && (cyc >= w_dly);
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      @(negedge aclk);
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      cyc++;
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("wr_handshake_timeout", 32'(aw_done && w_done), 32'd1);
    model_write(addr, data, strb);
    check("wr_bvalid_latency", 32'(bus.bvalid), 32'd1);
    check("wr_bresp", 32'(bus.bresp), 32'(exp_resp(addr)));
    check_all_regs("wr_regs_o");
    resp0 = bus.bresp;
    for (int i = 0; i < b_stall; i++) begin
      @(negedge aclk);
      check("wr_bvalid_hold", 32'(bus.bvalid), 32'd1);
      check("wr_bresp_hold", 32'(bus.bresp), 32'(resp0));
      check("wr_awready_low", 32'(bus.awready), 32'd0);
      check("wr_wready_low", 32'(bus.wready), 32'd0);
    end
    bus.bready = 1'b1;
    @(negedge aclk);
    bus.bready = 1'b0;
    check("wr_bvalid_drop", 32'(bus.bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int stall);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    int cyc;
    exp_d = model_read(addr);
    exp_r = exp_resp(addr);
    cyc = 0;
    bus.araddr = addr; bus.arvalid = 1'b1;
    while (!bus.arready && cyc < 20) begin
      @(negedge aclk);
      cyc++;
    end
    check("rd_arready_timeout", 32'(cyc < 20), 32'd1);
    @(negedge aclk);
    bus.arvalid = 1'b0;
    check("rd_rvalid", 32'(bus.rvalid), 32'd1);
    check("rd_rdata", bus.rdata, exp_d);
    check("rd_rresp", 32'(bus.rresp), 32'(exp_r));
    for (int i = 0; i < stall; i++) begin
      @(negedge aclk);
      check("rd_rvalid_hold", 32'(bus.rvalid), 32'd1);
      check("rd_rdata_hold", bus.rdata, exp_d);
      check("rd_rresp_hold", 32'(bus.rresp), 32'(exp_r));
      check("rd_arready_low", 32'(bus.arready), 32'd0);
    end
    bus.rready = 1'b1;
    @(negedge aclk);
    bus.rready = 1'b0;
    check("rd_rvalid_drop", 32'(bus.rvalid), 32'd0);
    check("rd_arready_back", 32'(bus.arready), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
    bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.rready = 0;
    for (int i = 0; i < N; i++) model[i] = 32'h0;

    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check_reset_state("reset");

    do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check("same_cycle_reg1", regs_o[63:32], 32'hDEADBEEF);

    do_write(32'h08, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    do_write(32'h08, 32'h11223344, 4'b0101, 3, 0, 5);
    check("w_first_strobe_reg2", regs_o[95:64], 32'hAA22CC44);

    do_read(32'h04, 4);

    // AR handshake and write commit to the same register on one edge
    bus.awaddr = 32'h0C; bus.awvalid = 1; bus.wdata = 32'h5; bus.wstrb = 4'hF; bus.wvalid = 1;
    bus.araddr = 32'h0C; bus.arvalid = 1;
    check("coll_ready", 32'(bus.awready && bus.wready && bus.arready), 32'd1);
    @(negedge aclk);
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    check("coll_rvalid", 32'(bus.rvalid), 32'd1);
    check("coll_old_rdata", bus.rdata, 32'h0);
    check("coll_bvalid", 32'(bus.bvalid), 32'd1);
    model_write(32'h0C, 32'h5, 4'hF);
    check("coll_reg3", regs_o[127:96], model[3]);
    bus.bready = 1; bus.rready = 1;
    @(negedge aclk);
    bus.bready = 0; bus.rready = 0;
    do_read(32'h0C, 0);

    do_write(32'h20, 32'hCAFEF00D, 4'hF, 1, 0, 0);
    check_all_regs("oor_regs_unchanged");
    do_read(32'h20, 1);
    do_read(32'h23, 0);

    for (int it = 0; it < 60; it++) begin
      a = ($urandom_range(0, 9) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2));
      else
        do_read(a, $urandom_range(0, 3));
    end

    do_write(32'h10, 32'h12345678, 4'hF, 0, 0, 0);
    bus.awaddr = 32'h14; bus.awvalid = 1;
    check("rst_aw_ready", 32'(bus.awready), 32'd1);
    @(negedge aclk);
    bus.awvalid = 0;
    bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF;
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < N; i++) model[i] = 32'h0;
    check_reset_state("midreset");
    bus.wvalid = 1;
    @(negedge aclk);
    bus.wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      check("rst_no_commit_bvalid", 32'(bus.bvalid), 32'd0);
      check_all_regs("rst_no_commit_regs");
      @(negedge aclk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
